// File: rtl/uc_multiciclo.sv
// Multicycle RV32 control unit: Moore FSM sequencing fetch/decode/execute,
// plus combinational immediate-format and ALU-control decode.
module uc_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       adrSrc,
    output logic       illegalOp,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, JAL, ALUWB, BEQ
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state;
    logic [1:0] alu_op;

    // State register with next-state selection; reset returns to FETCH at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    state <= memReady ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_I:         state <= EXECUTEI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= memReady ? MEMWB : MEMREAD;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= memReady ? FETCH : MEMWRITE;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                JAL:      state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    // Per-state control outputs; strobes are forced low while reset is held
    always_comb begin
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        illegalOp = 1'b0;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        resultSrc = 2'b00;
        alu_op    = 2'b00;
        case (state)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = memReady;
                pcWrite   = memReady;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegalOp = 1'b0;
                    default:                                  illegalOp = 1'b1;
                endcase
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD:  adrSrc = 1'b1;
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcWrite = 1'b1;
            end
            ALUWB:    regWrite = 1'b1;
            BEQ: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b01;
                pcWrite = zero;
            end
            default: ;
        endcase
        if (reset) begin
            pcWrite   = 1'b0;
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            memWrite  = 1'b0;
            illegalOp = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    // ALU operation select; only R-type (op[5]=1) turns f7 into a subtract
    always_comb begin
        case (alu_op)
            2'b00: aluControl = 3'b000;
            2'b01: aluControl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  aluControl = (op[5] & f7) ? 3'b001 : 3'b000;
                    3'b010:  aluControl = 3'b101;
                    3'b110:  aluControl = 3'b011;
                    3'b111:  aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            default: aluControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed scoreboard bench for uc_multiciclo: each stimulus cycle pushes the
// hand-derived output vector; a negedge monitor pops and compares.
module tb_uc_multiciclo;

    logic       clk, reset;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zero, memReady;
    logic       pcWrite, irWrite, regWrite, memWrite, adrSrc, illegalOp;
    logic [1:0] aluSrcA, aluSrcB, resultSrc, immSrc;
    logic [2:0] aluControl;

    uc_multiciclo dut (
        .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
        .regWrite(regWrite), .memWrite(memWrite), .adrSrc(adrSrc),
        .illegalOp(illegalOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .resultSrc(resultSrc), .immSrc(immSrc), .aluControl(aluControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcW,irW,regW,memW,adrSrc,ill,srcA,srcB,resSrc,imm,aluCtl}
    logic [16:0] dv;
    assign dv = {pcWrite, irWrite, regWrite, memWrite, adrSrc, illegalOp,
                 aluSrcA, aluSrcB, resultSrc, immSrc, aluControl};

    typedef struct {
        string       nm;
        logic [16:0] e;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;
    logic [1:0] imm_cur;

    task automatic chk(input string nm, input logic [16:0] a, input logic [16:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %b want %b", nm, a, e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            chk(it.nm, dv, it.e);
        end
    end

    function automatic logic [16:0] ev(input logic pcw, irw, rw, mw, adr, ill,
                                       input logic [1:0] asa, asb, rs,
                                       input logic [2:0] ac);
        return {pcw, irw, rw, mw, adr, ill, asa, asb, rs, imm_cur, ac};
    endfunction

    // Expected vectors per state, written out from the control table
    function automatic logic [16:0] F(input logic mr);
        return ev(mr, mr, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000);
    endfunction
    function automatic logic [16:0] D(input logic ill);
        return ev(0, 0, 0, 0, 0, ill, 2'b01, 2'b01, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] MA();
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] MR();
        return ev(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] MWB();
        return ev(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000);
    endfunction
    function automatic logic [16:0] MW();
        return ev(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] ER(input logic [2:0] ac);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ac);
    endfunction
    function automatic logic [16:0] EI(input logic [2:0] ac);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ac);
    endfunction
    function automatic logic [16:0] J();
        return ev(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] AW();
        return ev(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [16:0] B(input logic z);
        return ev(z, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001);
    endfunction

    task automatic set_ins(input logic [6:0] o, input logic [2:0] g3,
                           input logic g7, input logic [1:0] imm);
        op = o; f3 = g3; f7 = g7; imm_cur = imm;
    endtask

    // One clock of stimulus: drive inputs, queue the expectation, advance
    task automatic cyc(input string nm, input logic mr, input logic z,
                       input logic [16:0] e);
        memReady = mr;
        zero     = z;
        sb.push_back('{nm, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; memReady = 1'b1; zero = 1'b0;
        set_ins(7'b0000000, 3'b000, 1'b0, 2'b00);
        #3;
        chk("reset_state", dv, F(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // add, with one fetch stall first
        set_ins(7'b0110011, 3'b000, 1'b0, 2'b00);
        cyc("add_f_stall", 0, 0, F(0));
        cyc("add_fetch",   1, 0, F(1));
        cyc("add_decode",  0, 0, D(0));
        cyc("add_exec",    0, 0, ER(3'b000));
        cyc("add_wb",      0, 0, AW());

        // sub
        set_ins(7'b0110011, 3'b000, 1'b1, 2'b00);
        cyc("sub_fetch",  1, 0, F(1));
        cyc("sub_decode", 0, 0, D(0));
        cyc("sub_exec",   0, 0, ER(3'b001));
        cyc("sub_wb",     0, 0, AW());

        // addi with f7=1 must stay add
        set_ins(7'b0010011, 3'b000, 1'b1, 2'b00);
        cyc("addi_fetch",  1, 0, F(1));
        cyc("addi_decode", 0, 0, D(0));
        cyc("addi_exec",   0, 0, EI(3'b000));
        cyc("addi_wb",     0, 0, AW());

        // slt / or / and / unlisted f3
        set_ins(7'b0110011, 3'b010, 1'b0, 2'b00);
        cyc("slt_fetch", 1, 0, F(1)); cyc("slt_decode", 0, 0, D(0));
        cyc("slt_exec",  0, 0, ER(3'b101)); cyc("slt_wb", 0, 0, AW());
        set_ins(7'b0110011, 3'b110, 1'b0, 2'b00);
        cyc("or_fetch", 1, 0, F(1)); cyc("or_decode", 0, 0, D(0));
        cyc("or_exec",  0, 0, ER(3'b011)); cyc("or_wb", 0, 0, AW());
        set_ins(7'b0010011, 3'b111, 1'b0, 2'b00);
        cyc("andi_fetch", 1, 0, F(1)); cyc("andi_decode", 0, 0, D(0));
        cyc("andi_exec",  0, 0, EI(3'b010)); cyc("andi_wb", 0, 0, AW());
        set_ins(7'b0110011, 3'b001, 1'b1, 2'b00);
        cyc("sll_fetch", 1, 0, F(1)); cyc("sll_decode", 0, 0, D(0));
        cyc("sll_exec",  0, 0, ER(3'b000)); cyc("sll_wb", 0, 0, AW());

        // lw with two memory wait cycles: 7 cycles total
        set_ins(7'b0000011, 3'b010, 1'b0, 2'b00);
        cyc("lw_fetch",  1, 0, F(1));
        cyc("lw_decode", 0, 0, D(0));
        cyc("lw_memadr", 0, 0, MA());
        cyc("lw_rd_w0",  0, 0, MR());
        cyc("lw_rd_w1",  0, 0, MR());
        cyc("lw_rd_ok",  1, 0, MR());
        cyc("lw_wb",     0, 0, MWB());
        cyc("lw_next_f", 0, 0, F(0));

        // beq taken / not taken
        set_ins(7'b1100011, 3'b000, 1'b0, 2'b10);
        cyc("beqt_fetch",  1, 1, F(1));
        cyc("beqt_decode", 0, 1, D(0));
        cyc("beqt_br",     0, 1, B(1));
        cyc("beqn_fetch",  1, 0, F(1));
        cyc("beqn_decode", 0, 0, D(0));
        cyc("beqn_br",     0, 0, B(0));

        // jal
        set_ins(7'b1101111, 3'b000, 1'b0, 2'b11);
        cyc("jal_fetch",  1, 0, F(1));
        cyc("jal_decode", 0, 0, D(0));
        cyc("jal_jump",   0, 0, J());
        cyc("jal_wb",     0, 0, AW());

        // illegal opcode
        set_ins(7'b1111111, 3'b000, 1'b0, 2'b00);
        cyc("ill_fetch",  1, 0, F(1));
        cyc("ill_decode", 0, 0, D(1));
        cyc("ill_next_f", 0, 0, F(0));

        // sw, normal then one wait cycle
        set_ins(7'b0100011, 3'b010, 1'b0, 2'b01);
        cyc("sw_fetch",  1, 0, F(1));
        cyc("sw_decode", 0, 0, D(0));
        cyc("sw_memadr", 0, 0, MA());
        cyc("sw_write",  1, 0, MW());
        cyc("sw2_fetch", 1, 0, F(1));
        cyc("sw2_decode",0, 0, D(0));
        cyc("sw2_memadr",0, 0, MA());
        cyc("sw2_wait",  0, 0, MW());
        cyc("sw2_write", 1, 0, MW());

        // sw stalled in MEMWRITE, reset pulsed between edges
        cyc("swr_fetch",  1, 0, F(1));
        cyc("swr_decode", 0, 0, D(0));
        cyc("swr_memadr", 0, 0, MA());
        memReady = 1'b0;
        sb.push_back('{"swr_wait", MW()});
        #5;
        reset = 1'b1; memReady = 1'b1;
        #1;
        chk("swr_async_reset", dv, F(0));
        memReady = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        cyc("swr_post_f0",  0, 0, F(0));
        cyc("swr_post_f1",  1, 0, F(1));
        cyc("swr_post_dec", 0, 0, D(0));
        cyc("swr_post_ma",  0, 0, MA());
        cyc("swr_post_mw",  1, 0, MW());
        cyc("swr_post_f",   0, 0, F(0));

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 SHALL have one clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-002 SHALL have reset, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have these inputs:
- op, 7 bits: opcode from the instruction register.
- f3, 3 bits: funct3.
- f7, 1 bit: funct7[5].
- zero, 1 bit: ALU zero flag.
- memReady, 1 bit: memory access completes this cycle.
REQ-004 SHALL have these outputs:
- pcWrite, irWrite, regWrite, memWrite, adrSrc, illegalOp: 1 bit each.
- aluSrcA, aluSrcB, resultSrc, immSrc: 2 bits each.
- aluControl: 3 bits.

Function
REQ-005 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, JAL, ALUWB, BEQ.
REQ-006 SHALL use these mux encodings:
- aluSrcA: 00 PC, 01 oldPC, 10 rs1.
- aluSrcB: 00 rs2, 01 immExt, 10 constant 4.
- resultSrc: 00 aluOut, 01 memData, 10 aluResult.
- adrSrc: 0 PC, 1 result.
REQ-007 SHALL drive every output not listed for a state as 0 (all-zero vector for buses).
REQ-008 FETCH SHALL drive adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, and irWrite=pcWrite=memReady. It stays in FETCH while memReady=0 and goes to DECODE when memReady=1.
REQ-009 DECODE SHALL drive aluSrcA=01, aluSrcB=01, aluOp=00. Next state by op:
- 0000011 or 0100011: MEMADR.
- 0110011: EXECUTER.
- 0010011: EXECUTEI.
- 1100011: BEQ.
- 1101111: JAL.
- Any other op: FETCH, with illegalOp=1 for exactly that DECODE cycle.
REQ-010 MEMADR SHALL drive aluSrcA=10, aluSrcB=01, aluOp=00. Next state is MEMREAD if op=0000011, otherwise MEMWRITE.
REQ-011 MEMREAD SHALL drive adrSrc=1, resultSrc=00. It holds until memReady=1, then goes to MEMWB.
REQ-012 MEMWB SHALL drive resultSrc=01, regWrite=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive adrSrc=1, resultSrc=00, memWrite=1. It holds, with memWrite continuously asserted, until memReady=1, then goes to FETCH.
REQ-014 EXECUTER SHALL drive aluSrcA=10, aluSrcB=00, aluOp=10. EXECUTEI SHALL drive aluSrcA=10, aluSrcB=01, aluOp=10. Both go to ALUWB.
REQ-015 JAL SHALL drive aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1, then go to ALUWB.
REQ-016 ALUWB SHALL drive resultSrc=00, regWrite=1, then go to FETCH.
REQ-017 BEQ SHALL drive aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=zero, then go to FETCH.
REQ-018 immSrc SHALL be decoded combinationally from op in every state:
- I-type (0000011, 0010011): 00.
- S (0100011): 01.
- B (1100011): 10.
- J (1101111): 11.
- Any other op: 00.
REQ-019 aluControl SHALL be decoded from the internal 2-bit aluOp:
- aluOp 00: 000 (add).
- aluOp 01: 001 (sub).
- aluOp 10 and f3=000: 001 if op[5]&f7, else 000.
- aluOp 10 and f3=010: 101 (slt).
- aluOp 10 and f3=110: 011 (or).
- aluOp 10 and f3=111: 010 (and).
- aluOp 10 with any other f3: 000.
REQ-020 Cycle counts with memReady=1 on the first request SHALL be:
- R-type and I-type ALU: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- jal: 4.
Each extra memReady=0 cycle adds 1 to the count.
REQ-021 op, f3 and f7 SHALL be treated as stable from DECODE through the end of the instruction; the block SHALL NOT latch them.

Reset
REQ-022 reset=1 SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-023 While reset=1, pcWrite, irWrite, regWrite, memWrite and illegalOp SHALL be 0, regardless of memReady.
REQ-024 Reset asserted mid-instruction, including MEMWRITE with memReady=0, SHALL abandon the instruction. After release, execution resumes at FETCH on the next rising edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- add (op=0110011, f3=000, f7=0), memReady=1 -> FETCH, DECODE, EXECUTER, ALUWB; aluControl=000 in EXECUTER; regWrite=1 only in cycle 4.
- sub (f7=1) -> aluControl=001 in EXECUTER. addi with f7=1 (op[5]=0) -> aluControl=000.
- lw with memReady=0 for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, adrSrc=1 throughout; total 7 cycles; regWrite pulses once in MEMWB.
- beq with zero=1 -> pcWrite=1 in cycle 3. beq with zero=0 -> pcWrite=0 in all cycles after FETCH.
- op=1111111 -> illegalOp=1 in DECODE only, no regWrite/memWrite, next state FETCH.
- sw with memReady=0, reset pulsed asynchronously between clock edges -> memWrite drops to 0 at once, state is FETCH; no extra write after release.
